// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter granting eight requesters access to one shared 3-8 decoder.
// Grants last until done, until the owner drops its request, or until MAX_HOLD cycles have passed.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic [2:0] g_en,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_e;

    state_e      state_q;
    logic [7:0]  grant_q;
    logic [2:0]  idx_q;
    logic        valid_q;
    logic [2:0]  gen_q;
    logic        timeout_q;
    logic [2:0]  ptr_q;
    logic [7:0]  hold_q;

    logic [2:0]  pickIdx;
    logic        pickFound;
    logic [2:0]  candIdx;
    logic        holdHit;
    logic        reqDrop;
    logic        endGrant;

    // Search upward from the round-robin pointer; the 3-bit add wraps 7 back to 0.
    always_comb begin
        pickIdx   = ptr_q;
        pickFound = 1'b0;
        candIdx   = ptr_q;
        for (int k = 0; k < 8; k++) begin
            candIdx = ptr_q + 3'(k);
            if (!pickFound && req[candIdx]) begin
                pickIdx   = candIdx;
                pickFound = 1'b1;
            end
        end
    end

    assign holdHit  = (hold_q == 8'(MAX_HOLD));
    assign reqDrop  = !req[idx_q];
    assign endGrant = done || reqDrop || holdHit;

    // The first GRANT cycle counts as hold 1, so the limit check sees exactly MAX_HOLD grant cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 8'h00;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            gen_q     <= 3'b000;
            timeout_q <= 1'b0;
            ptr_q     <= 3'd0;
            hold_q    <= 8'd0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pickFound) begin
                        grant_q <= 8'h01 << pickIdx;
                        idx_q   <= pickIdx;
                        valid_q <= 1'b1;
                        gen_q   <= 3'b100;
                        hold_q  <= 8'd1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (endGrant) begin
                        grant_q   <= 8'h00;
                        valid_q   <= 1'b0;
                        gen_q     <= 3'b000;
                        ptr_q     <= idx_q + 3'd1;
                        timeout_q <= holdHit && !done && !reqDrop;
                        state_q   <= GAP;
                    end else if (hold_q != 8'hFF) begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign g_en      = gen_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: a table of per-cycle vectors feeds a scoreboard queue,
// plus hand-written sequences for power-on reset and a reset arriving mid-grant.
module tb_rr_arbiter_8;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [2:0] g_en;
    logic       timeout;

    rr_arbiter_8 #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .g_en      (g_en),
        .timeout   (timeout)
    );

    typedef struct {
        bit         isReset;
        logic [7:0] req;
        logic       done;
        logic [7:0] expGrant;
        logic [2:0] expIdx;
        logic       expTimeout;
    } vec_t;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       timeout;
        int         row;
    } exp_t;

    vec_t vecTable[$];
    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL row%0d %s: got %0h expected %0h", row, name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [7:0] r, input logic d, input logic [7:0] g,
                               input logic [2:0] i, input logic t);
        vec_t e;
        e.isReset    = 1'b0;
        e.req        = r;
        e.done       = d;
        e.expGrant   = g;
        e.expIdx     = i;
        e.expTimeout = t;
        return e;
    endfunction

    function automatic void addV(input logic [7:0] r, input logic d, input logic [7:0] g,
                                 input logic [2:0] i, input logic t);
        vecTable.push_back(v(r, d, g, i, t));
    endfunction

    function automatic void addReset();
        vec_t e;
        e = v(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        e.isReset = 1'b1;
        vecTable.push_back(e);
    endfunction

    // Drive one cycle of inputs and record what the arbiter must show after the next edge.
    task automatic applyStimulus(input vec_t vec, input int row);
        exp_t e;
        @(negedge clk);
        req  = vec.req;
        done = vec.done;
        e.grant   = vec.expGrant;
        e.idx     = vec.expIdx;
        e.timeout = vec.expTimeout;
        e.row     = row;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        logic expValid;
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = scoreboard.pop_front();
            expValid = (e.grant != 8'h00);
            compare("grant", e.row, grant, e.grant);
            compare("gnt_idx", e.row, {5'b0, gnt_idx}, {5'b0, e.idx});
            compare("gnt_valid", e.row, {7'b0, gnt_valid}, {7'b0, expValid});
            compare("g_en", e.row, {5'b0, g_en}, expValid ? 8'h04 : 8'h00);
            compare("timeout", e.row, {7'b0, timeout}, {7'b0, e.timeout});
            compare("onehot", e.row, {7'b0, $onehot0(grant)}, 8'h01);
        end
    endtask

    task automatic runVec(input vec_t vec, input int row);
        applyStimulus(vec, row);
        checkOutput();
    endtask

    // Reset lands half way between clock edges and must clear the outputs without any edge.
    task automatic pulseReset(input int row);
        @(negedge clk);
        req  = 8'h00;
        done = 1'b0;
        #1 rst = 1'b1;
        #1;
        compare("rst grant", row, grant, 8'h00);
        compare("rst gnt_idx", row, {5'b0, gnt_idx}, 8'h00);
        compare("rst gnt_valid", row, {7'b0, gnt_valid}, 8'h00);
        compare("rst g_en", row, {5'b0, g_en}, 8'h00);
        compare("rst timeout", row, {7'b0, timeout}, 8'h00);
        #1 rst = 1'b0;
    endtask

    initial begin
        $display("[TB] starting rr_arbiter_8 bench, MAX_HOLD=%0d", HOLD);
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        #2;
        compare("por grant", -1, grant, 8'h00);
        compare("por gnt_valid", -1, {7'b0, gnt_valid}, 8'h00);
        compare("por g_en", -1, {5'b0, g_en}, 8'h00);
        rst = 1'b0;

        // Single requester, done on the third grant cycle, two dead cycles, regrant.
        addReset();
        for (int k = 0; k < 3; k++) addV(8'h01, 1'b0, 8'h01, 3'd0, 1'b0);
        addV(8'h01, 1'b1, 8'h00, 3'd0, 1'b0);
        addV(8'h01, 1'b0, 8'h00, 3'd0, 1'b0);
        addV(8'h01, 1'b0, 8'h01, 3'd0, 1'b0);
        addV(8'h01, 1'b1, 8'h00, 3'd0, 1'b0);
        addV(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

        // All requesting with done held high: rotation 0..7,0; done in IDLE/GAP ignored.
        addReset();
        for (int k = 0; k < 8; k++) begin
            addV(8'hFF, 1'b1, 8'(1 << k), 3'(k), 1'b0);
            addV(8'hFF, 1'b1, 8'h00, 3'(k), 1'b0);
            addV(8'hFF, 1'b1, 8'h00, 3'(k), 1'b0);
        end
        addV(8'hFF, 1'b1, 8'h01, 3'd0, 1'b0);
        addV(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        addV(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

        // Hold limit: timeout pulse, regrant, then done on the limit cycle suppresses timeout.
        addReset();
        for (int k = 0; k < HOLD; k++) addV(8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
        addV(8'h20, 1'b0, 8'h00, 3'd5, 1'b1);
        addV(8'h20, 1'b0, 8'h00, 3'd5, 1'b0);
        for (int k = 0; k < HOLD; k++) addV(8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
        addV(8'h20, 1'b1, 8'h00, 3'd5, 1'b0);
        addV(8'h00, 1'b0, 8'h00, 3'd5, 1'b0);

        // Owner 3 drops its request; non-owner change mid-grant has no effect; ptr=4 skips to 5.
        addReset();
        addV(8'h08, 1'b0, 8'h08, 3'd3, 1'b0);
        addV(8'h28, 1'b0, 8'h08, 3'd3, 1'b0);
        addV(8'h20, 1'b0, 8'h00, 3'd3, 1'b0);
        addV(8'h20, 1'b0, 8'h00, 3'd3, 1'b0);
        addV(8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
        addV(8'h20, 1'b1, 8'h00, 3'd5, 1'b0);
        addV(8'h00, 1'b0, 8'h00, 3'd5, 1'b0);

        // Owner 7 releases with req=81: pointer wraps and bit 0 wins.
        addV(8'h80, 1'b0, 8'h80, 3'd7, 1'b0);
        addV(8'h81, 1'b1, 8'h00, 3'd7, 1'b0);
        addV(8'h81, 1'b0, 8'h00, 3'd7, 1'b0);
        addV(8'h81, 1'b0, 8'h01, 3'd0, 1'b0);
        addV(8'h81, 1'b1, 8'h00, 3'd0, 1'b0);
        addV(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

        for (int i = 0; i < vecTable.size(); i++) begin
            if (vecTable[i].isReset) pulseReset(i);
            else runVec(vecTable[i], i);
        end

        // Hand-written: move ptr to 3, start a grant for owner 4, then reset mid-grant.
        runVec(v(8'h04, 1'b0, 8'h04, 3'd2, 1'b0), 1000);
        runVec(v(8'h04, 1'b1, 8'h00, 3'd2, 1'b0), 1001);
        runVec(v(8'h10, 1'b0, 8'h00, 3'd2, 1'b0), 1002);
        runVec(v(8'h10, 1'b0, 8'h10, 3'd4, 1'b0), 1003);
        pulseReset(1004);
        for (int k = 0; k < HOLD; k++) runVec(v(8'h0C, 1'b0, 8'h04, 3'd2, 1'b0), 1005 + k);
        runVec(v(8'h0C, 1'b0, 8'h00, 3'd2, 1'b1), 1010);
        runVec(v(8'h0C, 1'b0, 8'h00, 3'd2, 1'b0), 1011);
        runVec(v(8'h0C, 1'b0, 8'h08, 3'd3, 1'b0), 1012);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
